// File: rtl/input_cond_pkg.sv
// Shared types and default timing for the board input conditioner.
// Timing defaults assume the 50 MHz CLOCK_50.
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HELD       = 2'd1,
        LONG_FIRED = 2'd2
    } power_state_t;

    localparam int unsigned KEY_POWER = 0;
    localparam int unsigned KEY_SEND  = 1;

    localparam int unsigned CLK_HZ                    = 50_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 50;  // 20 ms
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_HZ * 2;   // 2 s

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One push-button channel: 2-flop synchroniser, debounce counter,
// stable level and a one-cycle pulse on every accepted level change.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic edge_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta   <= 1'b1;
            key_sync   <= 1'b1;
            cnt        <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            key_meta   <= key_n;
            key_sync   <= key_meta;
            edge_pulse <= 1'b0;
            // key_sync is active-low; level is active-high
            if (~key_sync != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level      <= ~level;
                    cnt        <= '0;
                    edge_pulse <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: debounced keys, power short/long press events,
// send event with an atomic switch snapshot.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int unsigned NUM_SW            = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        key_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic              power_level,
    output logic              send_level,
    output logic              power_pulse,
    output logic              power_long,
    output logic              send_pulse,
    output logic [NUM_SW-1:0] sw_snapshot,
    output logic              sw_valid
);

    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic power_edge;
    logic send_edge;
    logic power_press;
    logic power_release;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_power (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n[KEY_POWER]),
        .level      (power_level),
        .edge_pulse (power_edge)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_send (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n[KEY_SEND]),
        .level      (send_level),
        .edge_pulse (send_edge)
    );

    assign power_press   = power_edge & power_level;
    assign power_release = power_edge & ~power_level;
    assign send_pulse    = send_edge & send_level & ~rst;

    // Switch sync plus one extra stage so the snapshot is last cycle's value.
    logic [NUM_SW-1:0] sw_meta;
    logic [NUM_SW-1:0] sw_sync;
    logic [NUM_SW-1:0] sw_sync_d;
    logic [NUM_SW-1:0] snap_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_sync_d <= '0;
            snap_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            sw_meta   <= sw_raw;
            sw_sync   <= sw_meta;
            sw_sync_d <= sw_sync;
            if (send_pulse) begin
                snap_q  <= sw_sync_d;
                valid_q <= 1'b1;
            end
        end
    end

    // Bypass makes the new snapshot visible in the send_pulse cycle itself.
    assign sw_snapshot = send_pulse ? sw_sync_d : snap_q;
    assign sw_valid    = valid_q | send_pulse;

    power_state_t      state;
    power_state_t      state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              short_c;
    logic              long_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        short_c       = 1'b0;
        long_c        = 1'b0;
        case (state)
            IDLE: begin
                if (power_press) begin
                    state_next    = HELD;
                    hold_cnt_next = '0;
                end
            end
            HELD: begin
                if (power_release) begin
                    short_c    = 1'b1;
                    state_next = IDLE;
                end else if (power_level) begin
                    if (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES))
                        hold_cnt_next = hold_cnt + 1'b1;
                    // Counter starts one cycle after the level rose, so this
                    // increment is the one that reaches LONG_PRESS_CYCLES.
                    if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                        long_c     = 1'b1;
                        state_next = LONG_FIRED;
                    end
                end
            end
            LONG_FIRED: begin
                if (power_release)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign power_pulse = short_c & ~rst;
    assign power_long  = long_c & ~rst;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an event scoreboard: predicted
// pulse events are queued at stimulus time and matched when pulses appear.
module tb_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  key_n;
    logic [17:0] sw_raw;
    logic        power_level;
    logic        send_level;
    logic        power_pulse;
    logic        power_long;
    logic        send_pulse;
    logic [17:0] sw_snapshot;
    logic        sw_valid;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .NUM_SW            (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .power_level (power_level),
        .send_level  (send_level),
        .power_pulse (power_pulse),
        .power_long  (power_long),
        .send_pulse  (send_pulse),
        .sw_snapshot (sw_snapshot),
        .sw_valid    (sw_valid)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // {cycle, power_pulse, power_long, send_pulse, snapshot, valid}
    typedef logic [53:0] ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk_ev(int unsigned c, logic pp, logic pl, logic sp,
                                  logic [17:0] snap, logic v);
        return {c, pp, pl, sp, snap, v};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int unsigned c);
        while (cyc < c) step(1);
    endtask

    // Any pulse must match the oldest predicted event exactly.
    always @(negedge clk) begin
        if (power_pulse === 1'b1 || power_long === 1'b1 || send_pulse === 1'b1) begin
            ev_t e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            check("event", 64'(mk_ev(cyc, power_pulse, power_long, send_pulse,
                                     sw_snapshot, sw_valid)), 64'(e));
        end
    end

    initial begin
        int unsigned t;
        int unsigned p;
        int unsigned r;

        rst    = 1'b1;
        key_n  = 2'b11;
        sw_raw = '0;
        step(3);
        check("rst_flags", 64'({power_level, send_level, power_pulse, power_long,
                                send_pulse, sw_valid}), 64'(0));
        check("rst_snap", 64'(sw_snapshot), 64'(0));
        rst = 1'b0;
        step(2);

        // Bounce on send: toggles every 2 cycles, then steady low.
        for (int i = 0; i < 6; i++) begin
            key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        key_n[1] = 1'b0;
        t = cyc;
        exp_q.push_back(mk_ev(t + 6, 1'b0, 1'b0, 1'b1, 18'h0, 1'b1));
        wait_until(t + 5);
        check("bounce_level_early", 64'(send_level), 64'(0));
        step(1);
        check("bounce_level_rise", 64'(send_level), 64'(1));
        step(4);
        key_n[1] = 1'b1;
        step(10);
        check("send_released", 64'(send_level), 64'(0));

        // Snapshot taken with the send press, held afterwards.
        sw_raw = 18'h2A5A5;
        step(3);
        key_n[1] = 1'b0;
        p = cyc;
        exp_q.push_back(mk_ev(p + 6, 1'b0, 1'b0, 1'b1, 18'h2A5A5, 1'b1));
        step(10);
        key_n[1] = 1'b1;
        step(10);
        sw_raw = '0;
        step(5);
        check("snap_hold", 64'(sw_snapshot), 64'(18'h2A5A5));
        check("valid_hold", 64'(sw_valid), 64'(1));

        // Short power press.
        key_n[0] = 1'b0;
        p = cyc;
        wait_until(p + 6);
        check("power_level_rise", 64'(power_level), 64'(1));
        step(10);
        key_n[0] = 1'b1;
        r = cyc;
        exp_q.push_back(mk_ev(r + 6, 1'b1, 1'b0, 1'b0, 18'h2A5A5, 1'b1));
        step(12);
        check("power_level_fall", 64'(power_level), 64'(0));

        // Long power press: single power_long, nothing on release.
        key_n[0] = 1'b0;
        p = cyc;
        exp_q.push_back(mk_ev(p + 6 + LP, 1'b0, 1'b1, 1'b0, 18'h2A5A5, 1'b1));
        step(40);
        key_n[0] = 1'b1;
        step(12);
        check("long_released", 64'(power_level), 64'(0));

        // Reset at hold count 10 with the key still held.
        key_n[0] = 1'b0;
        p = cyc;
        wait_until(p + 17);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_level", 64'(power_level), 64'(0));
        check("midrst_valid", 64'(sw_valid), 64'(0));
        check("midrst_snap", 64'(sw_snapshot), 64'(0));
        exp_q.push_back(mk_ev(p + 24 + LP, 1'b0, 1'b1, 1'b0, 18'h0, 1'b0));
        wait_until(p + 23);
        check("rerise_early", 64'(power_level), 64'(0));
        step(1);
        check("rerise", 64'(power_level), 64'(1));
        step(25);
        key_n[0] = 1'b1;
        step(12);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
